// File: rtl/frac_div_pkg.sv
// Shared types and helpers for the fractional clock-divider scheduler.
//   INT_W / FRAC_W  : widths of the integer part and of the fraction num/den
//   cfg_t           : one divide ratio N + num/den
//   cfg_legal()     : N >= 2, den >= 1, num < den
//   state_t         : scheduler FSM states
package frac_div_pkg;

  localparam int INT_W       = 8;
  localparam int FRAC_W      = 4;
  localparam int DEF_RST_INT = 2;

  typedef struct packed {
    logic [INT_W-1:0]  int_part;
    logic [FRAC_W-1:0] num;
    logic [FRAC_W-1:0] den;
  } cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  function automatic logic cfg_legal(input cfg_t c);
    return (c.int_part >= INT_W'(2)) && (c.den != '0) && (c.num < c.den);
  endfunction

endpackage

// File: rtl/frac_div_phase_acc.sv
// Bresenham phase accumulator: decides whether the period that starts now is
// long (N+1) or short (N), and advances the residue when a period starts.
//   clk, rst_n : clock, async active-low reset
//   load_zero  : treat the residue as 0 for this decision and clear it
//   step       : a period starts this cycle, commit the new residue
//   num, den   : fraction of the ratio in force for the starting period
//   long_next  : the starting period is N+1 cycles
//   acc        : current residue, always < den
module frac_div_phase_acc
  import frac_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_zero,
  input  logic              step,
  input  logic [FRAC_W-1:0] num,
  input  logic [FRAC_W-1:0] den,
  output logic              long_next,
  output logic [FRAC_W-1:0] acc
);

  // One extra bit so acc + num cannot wrap before the compare.
  logic [FRAC_W:0] base;
  logic [FRAC_W:0] sum;
  logic [FRAC_W:0] acc_nxt;

  assign base      = load_zero ? '0 : {1'b0, acc};
  assign sum       = base + {1'b0, num};
  assign long_next = (sum >= {1'b0, den});
  assign acc_nxt   = long_next ? (sum - {1'b0, den}) : sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (step) begin
      // NOTE: non-blocking for every register so all flops see pre-edge values.
      acc <= FRAC_W'(acc_nxt);
    end else if (load_zero) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/frac_div_sched.sv
// Fractional clock-divider scheduler: emits periods of N or N+1 input cycles
// so the average period is N + num/den. Ratios arrive over valid/ready and
// only take effect at period boundaries, so div_clk never glitches.
//   clk, rst_n            : clock, async active-low reset
//   en                    : run request (level)
//   cfg_valid / cfg_ready : config handshake
//   cfg_int/num/den       : offered ratio N + num/den
//   cfg_err               : one-cycle pulse, offered ratio was illegal and dropped
//   div_clk               : divided clock, low for the first ceil(P/2) cycles
//   div_tick              : pulse in the last cycle of each period
//   period_long           : current period is N+1 cycles
//   active                : a period is in progress
module frac_div_sched
  import frac_div_pkg::*;
#(
  parameter int RST_INT = DEF_RST_INT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [INT_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_num,
  input  logic [FRAC_W-1:0] cfg_den,
  output logic              cfg_err,
  output logic              div_clk,
  output logic              div_tick,
  output logic              period_long,
  output logic              active
);

  localparam int   CNT_W     = INT_W + 1;  // P = 2^INT_W must be representable
  localparam cfg_t RESET_CFG = '{int_part: INT_W'(RST_INT), num: '0, den: FRAC_W'(1)};

  state_t           state, state_nxt;
  cfg_t             cur_cfg, shadow_cfg, cfg_in, eff_cfg;
  logic             pending;
  logic [CNT_W-1:0] cnt, cnt_nxt, plen, plen_nxt, p_next, half;
  logic             div_clk_nxt, div_tick_nxt, period_long_nxt;
  logic             is_idle, xfer, xfer_ok, boundary, start_new, apply, load_zero;
  logic             long_next;
  logic [FRAC_W-1:0] phase_acc;

  assign cfg_in    = '{int_part: cfg_int, num: cfg_num, den: cfg_den};
  assign cfg_ready = ~pending;
  assign is_idle   = (state == IDLE);
  assign active    = ~is_idle;
  assign xfer      = cfg_valid & cfg_ready;
  assign xfer_ok   = xfer & cfg_legal(cfg_in);
  assign boundary  = ~is_idle && (cnt == plen - CNT_W'(1));
  assign start_new = en & (is_idle | boundary);
  // A shadow loaded on a stopping boundary is still waiting once idle; it is
  // applied right away there so it is never stranded.
  assign apply     = pending & (is_idle | boundary);
  assign load_zero = is_idle | apply;

  // Ratio in force for a period starting this cycle.
  always_comb begin
    eff_cfg = cur_cfg;
    if (apply)                  eff_cfg = shadow_cfg;
    else if (is_idle && xfer_ok) eff_cfg = cfg_in;
  end

  frac_div_phase_acc u_phase_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_zero (load_zero),
    .step      (start_new),
    .num       (eff_cfg.num),
    .den       (eff_cfg.den),
    .long_next (long_next),
    .acc       (phase_acc)
  );

  assign p_next = {1'b0, eff_cfg.int_part} + (long_next ? CNT_W'(1) : CNT_W'(0));
  assign half   = (plen + CNT_W'(1)) >> 1;  // ceil(P/2)

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches.
    state_nxt       = state;
    cnt_nxt         = cnt;
    plen_nxt        = plen;
    div_clk_nxt     = div_clk;
    div_tick_nxt    = 1'b0;
    period_long_nxt = period_long;

    case (state)
      IDLE:    if (en)  state_nxt = RUN;
      RUN:     if (!en) state_nxt = DRAIN;
      DRAIN:   if (en)  state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    // Only en at the boundary decides whether another period follows.
    if (boundary) state_nxt = en ? RUN : IDLE;

    if (start_new) begin
      cnt_nxt         = '0;
      plen_nxt        = p_next;
      period_long_nxt = long_next;
      div_clk_nxt     = 1'b0;   // k=0 is always in the low half for P >= 2
    end else if (boundary) begin
      cnt_nxt         = '0;
      period_long_nxt = 1'b0;
      div_clk_nxt     = 1'b0;
    end else if (!is_idle) begin
      cnt_nxt      = cnt + CNT_W'(1);
      div_clk_nxt  = (cnt_nxt >= half);
      div_tick_nxt = (cnt_nxt == plen - CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: config and shadow registers are reset as well, so the first
      // period after reset is well defined without waiting for a handshake.
      state       <= IDLE;
      cnt         <= '0;
      plen        <= '0;
      div_clk     <= 1'b0;
      div_tick    <= 1'b0;
      period_long <= 1'b0;
      cfg_err     <= 1'b0;
      pending     <= 1'b0;
      cur_cfg     <= RESET_CFG;
      shadow_cfg  <= RESET_CFG;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      plen        <= plen_nxt;
      div_clk     <= div_clk_nxt;
      div_tick    <= div_tick_nxt;
      period_long <= period_long_nxt;
      cfg_err     <= xfer & ~cfg_legal(cfg_in);

      if (apply) begin
        cur_cfg <= shadow_cfg;
        pending <= 1'b0;
      end else if (is_idle && xfer_ok) begin
        cur_cfg <= cfg_in;
      end else if (xfer_ok) begin
        shadow_cfg <= cfg_in;
        pending    <= 1'b1;
      end
    end
  end

  // The residue is always a proper remainder of the ratio in force.
  assert property (@(posedge clk) disable iff (!rst_n) phase_acc < cur_cfg.den);

endmodule

// File: tb/tb_frac_div_sched.sv
module tb_frac_div_sched;

  logic       clk = 1'b0;
  logic       rst_n, en, cfg_valid;
  logic [7:0] cfg_int;
  logic [3:0] cfg_num, cfg_den;
  logic       cfg_ready, cfg_err, div_clk, div_tick, period_long, active;

  int n_checks = 0;
  int n_fail   = 0;

  frac_div_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_int     (cfg_int),
    .cfg_num     (cfg_num),
    .cfg_den     (cfg_den),
    .cfg_err     (cfg_err),
    .div_clk     (div_clk),
    .div_tick    (div_tick),
    .period_long (period_long),
    .active      (active)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; sampling point is 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int n, input int num, input int den);
    cfg_int   = 8'(n);
    cfg_num   = 4'(num);
    cfg_den   = 4'(den);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  // Starting at some cycle of a period, walk to its tick and one cycle past.
  task automatic measure(output int len, output int lowc, output bit lng,
                         output bit steady, output bit got_tick);
    len = 0; lowc = 0; lng = period_long; steady = 1'b1; got_tick = 1'b0;
    for (int i = 0; i < 600; i++) begin
      len++;
      if (div_clk === 1'b0) lowc++;
      if (period_long !== lng || active !== 1'b1) steady = 1'b0;
      if (div_tick === 1'b1) begin
        got_tick = 1'b1;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic stop_and_wait();
    en = 1'b0;
    for (int i = 0; i < 700 && active === 1'b1; i++) step();
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_timeout: active=%0b, required 0", active);
    end
  endtask

  task automatic test_reset();
    logic [5:0] got;
    #3;
    got = {div_clk, div_tick, period_long, active, cfg_err, cfg_ready};
    n_checks++;
    if (got !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 000001", got);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: active=%0b, required 0", active);
    end
  endtask

  task automatic test_ratio_8_7_10();
    int exp_len[10] = '{8, 9, 9, 8, 9, 9, 8, 9, 9, 9};
    int len, lowc, total, ticks;
    bit lng, steady, tk;
    offer(8, 7, 10);
    n_checks++;
    if (cfg_ready !== 1'b1 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_load: ready=%0b active=%0b, required 1 0", cfg_ready, active);
    end
    en = 1'b1;
    step();
    n_checks++;
    if (active !== 1'b1 || div_clk !== 1'b0 || div_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL first_start: active=%0b clk=%0b tick=%0b, required 1 0 0",
               active, div_clk, div_tick);
    end
    total = 0; ticks = 0;
    for (int p = 0; p < 10; p++) begin
      measure(len, lowc, lng, steady, tk);
      total += len;
      if (tk) ticks++;
      n_checks++;
      if (len !== exp_len[p] || lowc !== (exp_len[p] + 1) / 2 ||
          lng !== (exp_len[p] == 9) || !steady) begin
        n_fail++;
        $display("FAIL ratio_period_%0d: len=%0d low=%0d long=%0b steady=%0b, required %0d %0d %0b 1",
                 p, len, lowc, lng, steady, exp_len[p], (exp_len[p] + 1) / 2, exp_len[p] == 9);
      end
    end
    n_checks++;
    if (total !== 87 || ticks !== 10) begin
      n_fail++;
      $display("FAIL ratio_totals: cycles=%0d ticks=%0d, required 87 10", total, ticks);
    end
    stop_and_wait();
  endtask

  task automatic test_integer_3();
    int len, lowc;
    bit lng, steady, tk;
    offer(3, 0, 1);
    en = 1'b1;
    step();
    for (int p = 0; p < 4; p++) begin
      measure(len, lowc, lng, steady, tk);
      n_checks++;
      if (len !== 3 || lowc !== 2 || lng !== 1'b0 || !steady || !tk) begin
        n_fail++;
        $display("FAIL int3_period_%0d: len=%0d low=%0d long=%0b, required 3 2 0", p, len, lowc, lng);
      end
    end
  endtask

  task automatic test_midrun_cfg();
    int exp_len[3] = '{5, 6, 5};
    int len, lowc;
    bit lng, steady, tk;
    step();                        // k=1 of a {3,0,1} period
    cfg_int = 8'd5; cfg_num = 4'd1; cfg_den = 4'd2; cfg_valid = 1'b1;
    step();                        // transfer taken, now k=2
    cfg_valid = 1'b0;
    n_checks++;
    if (cfg_ready !== 1'b0 || div_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_pending: ready=%0b tick=%0b, required 0 1", cfg_ready, div_tick);
    end
    step();
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_apply_ready: ready=%0b, required 1", cfg_ready);
    end
    for (int p = 0; p < 3; p++) begin
      measure(len, lowc, lng, steady, tk);
      n_checks++;
      if (len !== exp_len[p] || lowc !== 3 || lng !== (exp_len[p] == 6) || !steady) begin
        n_fail++;
        $display("FAIL midrun_period_%0d: len=%0d low=%0d long=%0b, required %0d 3 %0b",
                 p, len, lowc, lng, exp_len[p], exp_len[p] == 6);
      end
    end
    // Offer in the tick cycle: takes effect one boundary later.
    for (int i = 0; i < 20 && div_tick !== 1'b1; i++) step();
    cfg_int = 8'd3; cfg_num = 4'd0; cfg_den = 4'd1; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    n_checks++;
    if (cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL boundary_xfer_pending: ready=%0b, required 0", cfg_ready);
    end
    measure(len, lowc, lng, steady, tk);
    n_checks++;
    if (len !== 5 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL boundary_xfer_old_ratio: len=%0d ready=%0b, required 5 1", len, cfg_ready);
    end
    measure(len, lowc, lng, steady, tk);
    n_checks++;
    if (len !== 3) begin
      n_fail++;
      $display("FAIL boundary_xfer_new_ratio: len=%0d, required 3", len);
    end
    stop_and_wait();
  endtask

  task automatic test_illegal_cfg();
    int bad[2][3] = '{'{1, 0, 1}, '{4, 3, 3}};
    int len, lowc;
    bit lng, steady, tk;
    for (int b = 0; b < 2; b++) begin
      offer(bad[b][0], bad[b][1], bad[b][2]);
      n_checks++;
      if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_%0d_err: err=%0b ready=%0b, required 1 1", b, cfg_err, cfg_ready);
      end
      step();
      n_checks++;
      if (cfg_err !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_%0d_pulse: err=%0b, required 0", b, cfg_err);
      end
    end
    en = 1'b1;
    step();
    measure(len, lowc, lng, steady, tk);
    n_checks++;
    if (len !== 3 || lowc !== 2) begin
      n_fail++;
      $display("FAIL illegal_ratio_kept: len=%0d low=%0d, required 3 2", len, lowc);
    end
    stop_and_wait();
  endtask

  task automatic test_stop_restart();
    int len, lowc;
    bit lng, steady, tk;
    offer(8, 7, 10);
    en = 1'b1;
    step();
    measure(len, lowc, lng, steady, tk);   // S8, now k=0 of L9
    step(); step();
    en = 1'b0;                              // dropped at k=2
    measure(len, lowc, lng, steady, tk);
    n_checks++;
    if (len !== 7 || lng !== 1'b1 || !tk) begin
      n_fail++;
      $display("FAIL stop_completes: remaining=%0d long=%0b tick=%0b, required 7 1 1", len, lng, tk);
    end
    n_checks++;
    if (active !== 1'b0 || div_clk !== 1'b0 || div_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_idle: active=%0b clk=%0b tick=%0b, required 0 0 0", active, div_clk, div_tick);
    end
    step();
    n_checks++;
    if (active !== 1'b0 || div_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_stays_idle: active=%0b clk=%0b, required 0 0", active, div_clk);
    end
    en = 1'b1;
    step();
    measure(len, lowc, lng, steady, tk);   // S8 again: acc cleared on restart
    n_checks++;
    if (len !== 8) begin
      n_fail++;
      $display("FAIL restart_acc_clear: len=%0d, required 8", len);
    end
    step(); step();
    en = 1'b0;
    step(); step(); step();
    en = 1'b1;                              // back at k=5
    measure(len, lowc, lng, steady, tk);
    n_checks++;
    if (len !== 4 || active !== 1'b1 || div_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL reraise_no_gap: remaining=%0d active=%0b clk=%0b, required 4 1 0", len, active, div_clk);
    end
    measure(len, lowc, lng, steady, tk);
    n_checks++;
    if (len !== 9 || lng !== 1'b1) begin
      n_fail++;
      $display("FAIL reraise_next_period: len=%0d long=%0b, required 9 1", len, lng);
    end
    stop_and_wait();
  endtask

  task automatic test_async_reset();
    int len, lowc;
    bit lng, steady, tk;
    logic [5:0] got;
    offer(8, 7, 10);
    en = 1'b1;
    step();
    measure(len, lowc, lng, steady, tk);   // S8, now k=0 of L9
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (div_clk !== 1'b1 || period_long !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_state: clk=%0b long=%0b, required 1 1", div_clk, period_long);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = {div_clk, div_tick, period_long, active, cfg_err, cfg_ready};
    n_checks++;
    if (got !== 6'b000001) begin
      n_fail++;
      $display("FAIL async_reset: got %b, required 000001", got);
    end
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    en = 1'b1;
    step();
    measure(len, lowc, lng, steady, tk);
    n_checks++;
    if (len !== 2 || lowc !== 1 || lng !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cfg_period: len=%0d low=%0d long=%0b, required 2 1 0", len, lowc, lng);
    end
    stop_and_wait();
  endtask

  task automatic test_max_ratio();
    int len, lowc;
    bit lng, steady, tk;
    offer(255, 14, 15);
    en = 1'b1;
    step();
    measure(len, lowc, lng, steady, tk);
    n_checks++;
    if (len !== 255 || lowc !== 128 || lng !== 1'b0) begin
      n_fail++;
      $display("FAIL max_short: len=%0d low=%0d long=%0b, required 255 128 0", len, lowc, lng);
    end
    measure(len, lowc, lng, steady, tk);
    n_checks++;
    if (len !== 256 || lowc !== 128 || lng !== 1'b1 || !steady) begin
      n_fail++;
      $display("FAIL max_long_wrap: len=%0d low=%0d long=%0b, required 256 128 1", len, lowc, lng);
    end
    stop_and_wait();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    cfg_int = '0; cfg_num = '0; cfg_den = '0;
    test_reset();
    test_ratio_8_7_10();
    test_integer_3();
    test_midrun_cfg();
    test_illegal_cfg();
    test_stop_restart();
    test_async_reset();
    test_max_ratio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
